// File: rtl/ins_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ins_pkg
// Purpose  : Shared constants for the instruction encode/write path: format
//            codes, loader state encoding, MIPS field bit positions, NOP word.
// Revision : 1.0 - initial release
// ============================================================================
package ins_pkg;

   // Instruction format codes carried on the fmt input
   localparam logic [1:0] FMT_R   = 2'd0;
   localparam logic [1:0] FMT_I   = 2'd1;
   localparam logic [1:0] FMT_J   = 2'd2;
   localparam logic [1:0] FMT_BAD = 2'd3;

   // Loader FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_WRITE  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Field bit positions inside the 32-bit instruction word
   localparam int OP_HI    = 31;
   localparam int OP_LO    = 26;
   localparam int RS_HI    = 25;
   localparam int RS_LO    = 21;
   localparam int RT_HI    = 20;
   localparam int RT_LO    = 16;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 11;
   localparam int SH_HI    = 10;
   localparam int SH_LO    = 6;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;
   localparam int IMM_HI   = 15;
   localparam int IMM_LO   = 0;
   localparam int JT_HI    = 25;
   localparam int JT_LO    = 0;

   // Word written in place of an instruction with an illegal format
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/ins_field_packer.sv
`default_nettype none
// ============================================================================
// Module   : ins_field_packer
// Purpose  : Combinational packing of decoded fields into a MIPS R/I/J word;
//            flags the illegal format and substitutes a NOP.
// Revision : 1.0 - initial release
// ============================================================================
module ins_field_packer
   import ins_pkg::*;
(
   input  logic [1:0]  i_fmt,
   input  logic [5:0]  i_control,
   input  logic [4:0]  i_rs,
   input  logic [4:0]  i_rt,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_shamt,
   input  logic [5:0]  i_funct,
   input  logic [15:0] i_imm,
   input  logic [25:0] i_jump,
   output logic [31:0] o_word,
   output logic        o_illegal
);

   // Place each field at its slot; fields unused by the format stay out of the word
   always_comb begin
      o_word    = NOP_WORD;
      o_illegal = 1'b0;
      unique case (i_fmt)
         FMT_R: begin
            o_word[OP_HI:OP_LO]       = i_control;
            o_word[RS_HI:RS_LO]       = i_rs;
            o_word[RT_HI:RT_LO]       = i_rt;
            o_word[RD_HI:RD_LO]       = i_rd;
            o_word[SH_HI:SH_LO]       = i_shamt;
            o_word[FUNCT_HI:FUNCT_LO] = i_funct;
         end
         FMT_I: begin
            o_word[OP_HI:OP_LO]   = i_control;
            o_word[RS_HI:RS_LO]   = i_rs;
            o_word[RT_HI:RT_LO]   = i_rt;
            o_word[IMM_HI:IMM_LO] = i_imm;
         end
         FMT_J: begin
            o_word[OP_HI:OP_LO] = i_control;
            o_word[JT_HI:JT_LO] = i_jump;
         end
         FMT_BAD: begin
            o_word    = NOP_WORD;
            o_illegal = 1'b1;
         end
         default: begin
            o_word    = NOP_WORD;
            o_illegal = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ins_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : ins_mem_loader
// Purpose  : Accepts decoded instruction tuples over valid/ready, encodes
//            them and writes a burst to consecutive instruction-memory
//            addresses through a write/acknowledge port.
// Revision : 1.0 - initial release
// ============================================================================
module ins_mem_loader
   import ins_pkg::*;
#(
   parameter int DEPTH  = 401,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] length,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        fmt,
   input  logic [5:0]        control,
   input  logic [4:0]        reg_read1,
   input  logic [4:0]        reg_read2,
   input  logic [4:0]        reg_write,
   input  logic [4:0]        shamt,
   input  logic [5:0]        alu_con,
   input  logic [15:0]       sign_ext,
   input  logic [25:0]       jump,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] count,
   output logic [1:0]        err
);

   localparam logic [ADDR_W-1:0] c_depth = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] c_one   = ADDR_W'(1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_rem;
   logic [ADDR_W-1:0] r_count;
   logic [1:0]        r_err;
   logic [31:0]       r_wdata;
   logic [31:0]       w_word;
   logic              w_illegal;
   logic [ADDR_W-1:0] w_addr_inc;
   logic              w_last;
   logic              w_start_empty;
   logic              w_start_oob;

   ins_field_packer u_packer (
      .i_fmt     (fmt),
      .i_control (control),
      .i_rs      (reg_read1),
      .i_rt      (reg_read2),
      .i_rd      (reg_write),
      .i_shamt   (shamt),
      .i_funct   (alu_con),
      .i_imm     (sign_ext),
      .i_jump    (jump),
      .o_word    (w_word),
      .o_illegal (w_illegal)
   );

   assign w_addr_inc    = r_addr + c_one;
   assign w_last        = (r_rem == c_one);
   assign w_start_empty = (length == '0);
   assign w_start_oob   = (start_addr >= c_depth);

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign count     = r_count;
   assign err       = r_err;

   // State register; reset aborts any burst in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and state-derived handshake/status outputs
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      mem_we      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (w_start_empty || w_start_oob) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_ACCEPT;
               end
            end
         end
         ST_ACCEPT: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               w_state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            mem_we = 1'b1;
            busy   = 1'b1;
            if (mem_ack) begin
               // Remaining-length exhaustion wins over hitting the top of memory
               if (w_last || (w_addr_inc == c_depth)) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_ACCEPT;
               end
            end
         end
         ST_DONE: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Burst address/length/count bookkeeping, sticky errors and the write word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_rem   <= '0;
         r_count <= '0;
         r_err   <= 2'b00;
         r_wdata <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (start && !w_start_empty) begin
                  if (w_start_oob) begin
                     r_err[1] <= 1'b1;
                  end else begin
                     r_addr  <= start_addr;
                     r_rem   <= length;
                     r_count <= '0;
                     r_err   <= 2'b00;
                  end
               end
            end
            ST_ACCEPT: begin
               if (in_valid) begin
                  r_wdata <= w_word;
                  if (w_illegal) begin
                     r_err[0] <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (mem_ack) begin
                  r_addr  <= w_addr_inc;
                  r_count <= r_count + c_one;
                  r_rem   <= r_rem - c_one;
                  if (!w_last && (w_addr_inc == c_depth)) begin
                     r_err[1] <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ins_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_mem_loader
// Purpose  : Randomised and directed bursts against a transaction-level model
//            of the instruction-memory loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ins_mem_loader;

   localparam int DEPTH  = 401;
   localparam int ADDR_W = 32;

   typedef struct {
      logic [1:0]  fmt;
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  sh;
      logic [5:0]  fn;
      logic [15:0] imm;
      logic [25:0] jt;
   } tup_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W-1:0] length;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        fmt;
   logic [5:0]        control;
   logic [4:0]        reg_read1;
   logic [4:0]        reg_read2;
   logic [4:0]        reg_write;
   logic [4:0]        shamt;
   logic [5:0]        alu_con;
   logic [15:0]       sign_ext;
   logic [25:0]       jump;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] count;
   logic [1:0]        err;

   int          n_vec = 0;
   int          n_miss = 0;
   int          m_count = 0;
   logic [1:0]  m_err = 2'b00;
   tup_t        dir_q[$];
   logic [31:0] obs_a[$];
   logic [31:0] obs_w[$];

   ins_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
      .length(length), .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
      .control(control), .reg_read1(reg_read1), .reg_read2(reg_read2),
      .reg_write(reg_write), .shamt(shamt), .alu_con(alu_con),
      .sign_ext(sign_ext), .jump(jump), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .busy(busy), .done(done),
      .count(count), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference encoding: field values weighted by their power-of-two position
   function automatic logic [31:0] enc(input tup_t t);
      logic [31:0] w;
      case (t.fmt)
         2'd0: w = 32'(t.op) * 32'h0400_0000 + 32'(t.rs) * 32'h0020_0000 +
                   32'(t.rt) * 32'h0001_0000 + 32'(t.rd) * 32'h0000_0800 +
                   32'(t.sh) * 32'h0000_0040 + 32'(t.fn);
         2'd1: w = 32'(t.op) * 32'h0400_0000 + 32'(t.rs) * 32'h0020_0000 +
                   32'(t.rt) * 32'h0001_0000 + 32'(t.imm);
         2'd2: w = 32'(t.op) * 32'h0400_0000 + 32'(t.jt);
         default: w = 32'h0;
      endcase
      return w;
   endfunction

   function automatic tup_t mk(input int f, input int op, input int rs, input int rt,
                               input int rd, input int sh, input int fn,
                               input int imm, input int jt);
      tup_t t;
      t.fmt = 2'(f);  t.op = 6'(op); t.rs = 5'(rs); t.rt = 5'(rt); t.rd = 5'(rd);
      t.sh  = 5'(sh); t.fn = 6'(fn); t.imm = 16'(imm); t.jt = 26'(jt);
      return t;
   endfunction

   function automatic tup_t rnd_tup();
      int r;
      r = int'($urandom_range(0, 7));
      return mk((r == 7) ? 3 : r % 3, int'($urandom), int'($urandom), int'($urandom),
                int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                int'($urandom));
   endfunction

   task automatic drive(input tup_t t);
      fmt = t.fmt; control = t.op; reg_read1 = t.rs; reg_read2 = t.rt;
      reg_write = t.rd; shamt = t.sh; alu_con = t.fn; sign_ext = t.imm; jump = t.jt;
   endtask

   // One burst: drive start, feed tuples, play memory with stalls, then check
   task automatic run_burst(input int a, input int l, input int smin, input int smax,
                            input int dmax);
      int          n;
      int          lat;
      int          exp_lat;
      int          stall_left;
      int          dly_left;
      bit          first;
      bit          ill;
      logic [31:0] hold_a;
      logic [31:0] hold_d;
      logic [31:0] exp_words[$];
      tup_t        t;
      if (l == 0 || a >= DEPTH) n = 0;
      else if (l < DEPTH - a)   n = l;
      else                      n = DEPTH - a;
      obs_a.delete();
      obs_w.delete();
      ill = 1'b0; first = 1'b1; stall_left = 0; hold_a = '0; hold_d = '0;
      dly_left = int'($urandom_range(0, dmax));
      exp_lat = 1;
      @(negedge clk);
      start = 1'b1; start_addr = 32'(a); length = 32'(l); in_valid = 1'b0;
      mem_ack = 1'($urandom);
      @(negedge clk);
      lat = 1;
      while (!done && lat < 300) begin
         start = 1'b0;
         if (in_ready) begin
            if (dly_left > 0) begin
               in_valid = 1'b0;
               dly_left--;
               exp_lat++;
            end else begin
               t = (dir_q.size() > 0) ? dir_q.pop_front() : rnd_tup();
               drive(t);
               in_valid = 1'b1;
               exp_words.push_back(enc(t));
               if (t.fmt == 2'd3) ill = 1'b1;
               stall_left = int'($urandom_range(smin, smax));
               exp_lat += 2 + stall_left;
               first = 1'b1;
            end
            mem_ack = 1'($urandom);
         end else if (mem_we) begin
            chk("ready_low_in_write", 64'(in_ready), 64'd0);
            if (first) begin
               hold_a = mem_addr; hold_d = mem_wdata; first = 1'b0;
            end else begin
               chk("stall_addr", 64'(mem_addr), 64'(hold_a));
               chk("stall_data", 64'(mem_wdata), 64'(hold_d));
            end
            if (stall_left > 0) begin
               mem_ack = 1'b0;
               stall_left--;
            end else begin
               mem_ack = 1'b1;
               obs_a.push_back(mem_addr);
               obs_w.push_back(mem_wdata);
               dly_left = int'($urandom_range(0, dmax));
            end
            drive(rnd_tup());
            in_valid = 1'($urandom);
         end else begin
            mem_ack  = 1'($urandom);
            in_valid = 1'b0;
         end
         if (busy && ($urandom_range(0, 2) == 0)) begin
            start = 1'b1;
            start_addr = 32'($urandom_range(0, 500));
            length = 32'($urandom_range(0, 9));
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
      chk("done_seen", 64'(done), 64'd1);
      chk("latency", 64'(lat), 64'(exp_lat));
      if (l != 0) begin
         if (a >= DEPTH) begin
            m_err[1] = 1'b1;
         end else begin
            m_count = n;
            m_err   = {(l > DEPTH - a), ill};
         end
      end
      chk("count", 64'(count), 64'(m_count));
      chk("err", 64'(err), 64'(m_err));
      chk("n_writes", 64'(obs_w.size()), 64'(n));
      for (int i = 0; i < obs_w.size() && i < n; i++) begin
         chk("wr_addr", 64'(obs_a[i]), 64'(a + i));
         chk("wr_data", 64'(obs_w[i]), 64'(exp_words[i]));
      end
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("idle_not_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; in_valid = 1'b0;
      mem_ack = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      #2;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // R-type add r3,r1,r2 at address 0
      dir_q.push_back(mk(0, 0, 1, 2, 3, 0, 'h20, 'hFFFF, 'h3FFFFFF));
      run_burst(0, 1, 0, 0, 0);
      chk("r_word", 64'(obs_w[0]), 64'h0000_0000_0022_1820);

      // lw then j
      dir_q.push_back(mk(1, 'h23, 1, 2, 31, 31, 63, 4, 'h155));
      dir_q.push_back(mk(2, 2, 7, 7, 7, 7, 7, 'h1234, 'h10));
      run_burst(10, 2, 0, 0, 0);
      chk("lw_word", 64'(obs_w[0]), 64'h0000_0000_8C22_0004);
      chk("j_word", 64'(obs_w[1]), 64'h0000_0000_0800_0010);

      // five-cycle memory stall
      run_burst(20, 1, 5, 5, 0);

      // illegal format inside a two-word burst
      dir_q.push_back(mk(1, 8, 3, 4, 0, 0, 0, 'h55, 0));
      dir_q.push_back(mk(3, 'h3F, 31, 31, 31, 31, 'h3F, 'hFFFF, 'h3FFFFFF));
      run_burst(30, 2, 0, 1, 1);
      chk("ill_word", 64'(obs_w[1]), 64'd0);
      chk("ill_err", 64'(err), 64'd1);

      // burst running off the top of memory
      run_burst(400, 3, 0, 0, 0);
      chk("ovf_err", 64'(err), 64'd2);
      chk("ovf_count", 64'(count), 64'd1);

      // empty burst and out-of-range start
      run_burst(50, 0, 0, 0, 0);
      run_burst(401, 2, 0, 0, 0);

      // asynchronous reset while a write is stalled
      @(negedge clk);
      start = 1'b1; start_addr = 32'd7; length = 32'd3;
      @(negedge clk);
      start = 1'b0;
      drive(mk(1, 9, 1, 1, 0, 0, 0, 'h77, 0));
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; mem_ack = 1'b0;
      chk("pre_rst_we", 64'(mem_we), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_mem_we", 64'(mem_we), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_mem_addr", 64'(mem_addr), 64'd0);
      chk("arst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_err", 64'(err), 64'd0);
      m_count = 0; m_err = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      mem_ack = 1'b1;
      @(negedge clk);
      chk("post_rst_done", 64'(done), 64'd0);
      chk("post_rst_we", 64'(mem_we), 64'd0);
      mem_ack = 1'b0;

      // randomised bursts, biased toward the top of memory
      for (int k = 0; k < 30; k++) begin
         int a;
         int sel;
         sel = int'($urandom_range(0, 9));
         if (sel < 5)      a = int'($urandom_range(0, 390));
         else if (sel < 9) a = int'($urandom_range(395, 400));
         else              a = int'($urandom_range(401, 405));
         run_burst(a, int'($urandom_range(0, 6)), 0, 3, 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
